// File: rtl/uart_pkg.sv
// Shared constants and elaboration-time helpers for the UART baud tick generator.
package uart_pkg;

    // Fraction width of the fixed-point divisor (units of 1/16 cycle).
    localparam int UART_FRAC_W = 4;

    // Smallest n with 2**n >= value; used to size the RX phase counter.
    function automatic int log2_ceil(input longint value);
        int     result;
        longint span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span << 1;
            result = result + 1;
        end
        return result;
    endfunction

    // Reset-default RX divisor in fixed point: sys_clk cycles per RX tick, scaled by 2**frac_w.
    function automatic longint def_div_x(input longint sys_clk, input longint baudrate,
                                         input longint oversample, input int frac_w);
        return (sys_clk << frac_w) / (baudrate * oversample);
    endfunction

endpackage

// File: rtl/uart_baud_gen_if.sv
// Control and tick bundle between a UART datapath (master) and the baud generator (slave).
interface uart_baud_gen_if
    import uart_pkg::*;
#(
    parameter int DIV_W   = 25,
    parameter int FRAC_W  = UART_FRAC_W,
    parameter int PHASE_W = 4
);
    logic               en;
    logic [DIV_W-1:0]   div_int;
    logic [FRAC_W-1:0]  div_frac;
    logic               div_load;
    logic               rx_resync;
    logic               tx_tick;
    logic               rx_tick;
    logic [PHASE_W-1:0] rx_phase;

    modport master (
        output en, div_int, div_frac, div_load, rx_resync,
        input  tx_tick, rx_tick, rx_phase
    );

    modport slave (
        input  en, div_int, div_frac, div_load, rx_resync,
        output tx_tick, rx_tick, rx_phase
    );
endinterface

// File: rtl/uart_frac_div.sv
// One fractional tick channel: a down-counter whose reload absorbs the carry of a
// fraction accumulator, so periods alternate between int and int+1 cycles and the
// long-run average equals int + frac/2**FRAC_W exactly.
module uart_frac_div
    import uart_pkg::*;
#(
    parameter int INT_W  = 25,
    parameter int FRAC_W = UART_FRAC_W
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              en,
    input  logic              restart,
    input  logic [INT_W-1:0]  int_part,
    input  logic [FRAC_W-1:0] frac_part,
    output logic              tick
);

    logic [INT_W-1:0]  cnt_reg;
    logic [FRAC_W-1:0] acc_reg;
    logic [FRAC_W:0]   acc_sum;
    logic [INT_W-1:0]  reload_val;

    // Carry out of the accumulator stretches the next period by one cycle.
    assign acc_sum    = {1'b0, acc_reg} + {1'b0, frac_part};
    assign reload_val = int_part - INT_W'(1) + INT_W'(acc_sum[FRAC_W]);

    // A restart in the same cycle as cnt==0 swallows the tick.
    assign tick = en && !rst && !restart && (cnt_reg == '0);

    // Counter/accumulator: hold at a full period while idle or restarting, else count down.
    always_ff @(posedge sys_clk) begin
        if (rst || !en || restart) begin
            cnt_reg <= int_part - INT_W'(1);
            acc_reg <= '0;
        end else if (cnt_reg == '0) begin
            cnt_reg <= reload_val;
            acc_reg <= acc_sum[FRAC_W-1:0];
        end else begin
            cnt_reg <= cnt_reg - INT_W'(1);
        end
    end

endmodule

// File: rtl/uart_baud_gen.sv
// Runtime-programmable UART baud tick generator: RX ticks at the oversampled rate,
// TX ticks once per bit, both as single-cycle strobes from fractional dividers.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter longint SYS_CLK    = 30000000,
    parameter longint BAUDRATE   = 9600,
    parameter int     OVERSAMPLE = 16,
    parameter int     DIV_W      = 25,
    parameter int     FRAC_W     = UART_FRAC_W
) (
    input  logic            sys_clk,
    input  logic            rst,
    uart_baud_gen_if.slave  bus
);

    localparam int OS_W     = log2_ceil(OVERSAMPLE);
    localparam int D_W      = DIV_W + FRAC_W;
    localparam int TX_INT_W = DIV_W + OS_W;
    localparam logic [D_W-1:0]   DEF_DIV_X   = D_W'(def_div_x(SYS_CLK, BAUDRATE, OVERSAMPLE, FRAC_W));
    localparam logic [DIV_W-1:0] MIN_DIV_INT = DIV_W'(2);

    logic [DIV_W-1:0]           clamped_int;
    logic [D_W-1:0]             load_div;
    logic [D_W-1:0]             div_shadow_reg;
    logic [D_W-1:0]             rx_div;
    logic [D_W-1:0]             tx_div_base;
    logic [TX_INT_W+FRAC_W-1:0] tx_div;
    logic [OS_W-1:0]            rx_phase_reg;
    logic                       rx_tick;
    logic                       tx_tick;

    // Divisor routing. Channels normally pick up the shadow value at their own next
    // reload; a load is forwarded straight through when it must take effect in the
    // same cycle (idle channels, or RX restarted together with the load), and reset
    // forces the default so the reload value matches the shadow being reset.
    always_comb begin
        clamped_int = (bus.div_int < MIN_DIV_INT) ? MIN_DIV_INT : bus.div_int;
        load_div    = {clamped_int, bus.div_frac};
        rx_div      = div_shadow_reg;
        tx_div_base = div_shadow_reg;
        if (rst) begin
            rx_div      = DEF_DIV_X;
            tx_div_base = DEF_DIV_X;
        end else if (bus.div_load) begin
            if (!bus.en || bus.rx_resync) begin
                rx_div = load_div;
            end
            if (!bus.en) begin
                tx_div_base = load_div;
            end
        end
    end

    // TX period is OVERSAMPLE RX periods: same fixed-point value shifted up.
    assign tx_div = {tx_div_base, {OS_W{1'b0}}};

    // Shadow divisor register, captured on every load.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            div_shadow_reg <= DEF_DIV_X;
        end else if (bus.div_load) begin
            div_shadow_reg <= load_div;
        end
    end

    // RX phase: rx_ticks since the last start-edge resync, wrapping at OVERSAMPLE.
    always_ff @(posedge sys_clk) begin
        if (rst || bus.rx_resync) begin
            rx_phase_reg <= '0;
        end else if (rx_tick) begin
            rx_phase_reg <= rx_phase_reg + OS_W'(1);
        end
    end

    uart_frac_div #(.INT_W(DIV_W), .FRAC_W(FRAC_W)) u_rx_div (
        .sys_clk   (sys_clk),
        .rst       (rst),
        .en        (bus.en),
        .restart   (bus.rx_resync),
        .int_part  (rx_div[D_W-1:FRAC_W]),
        .frac_part (rx_div[FRAC_W-1:0]),
        .tick      (rx_tick)
    );

    uart_frac_div #(.INT_W(TX_INT_W), .FRAC_W(FRAC_W)) u_tx_div (
        .sys_clk   (sys_clk),
        .rst       (rst),
        .en        (bus.en),
        .restart   (1'b0),
        .int_part  (tx_div[TX_INT_W+FRAC_W-1:FRAC_W]),
        .frac_part (tx_div[FRAC_W-1:0]),
        .tick      (tx_tick)
    );

    assign bus.rx_tick  = rx_tick;
    assign bus.tx_tick  = tx_tick;
    assign bus.rx_phase = rx_phase_reg;

endmodule

// File: tb/tb_uart_baud_gen.sv
// Self-checking bench for uart_baud_gen. The reference model tracks each channel's
// ideal tick position in sixteenths of a cycle; a tick is due in the cycle equal to
// the integer part of that position.
module tb_uart_baud_gen;

    localparam int     DIV_W  = 25;
    localparam int     FRAC_W = 4;
    localparam int     OS     = 16;
    localparam int     OS_W   = 4;
    localparam longint DEF_D  = 3125;   // 195 + 5/16, in sixteenths

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    uart_baud_gen_if #(.DIV_W(DIV_W), .FRAC_W(FRAC_W), .PHASE_W(OS_W)) bus ();

    uart_baud_gen #(
        .SYS_CLK    (30000000),
        .BAUDRATE   (9600),
        .OVERSAMPLE (OS),
        .DIV_W      (DIV_W),
        .FRAC_W     (FRAC_W)
    ) dut (
        .sys_clk (clk),
        .rst     (rst),
        .bus     (bus)
    );

    int     n_checks = 0;
    int     n_errors = 0;

    // Reference model state.
    longint t        = 0;       // index of the cycle being driven
    longint shadow_d = DEF_D;   // latest captured divisor, sixteenths
    longint x_rx     = 0;       // ideal position of next rx tick, sixteenths of a cycle
    longint x_tx     = 0;
    int     phase    = 0;
    bit     model_valid = 1'b0;

    // Observations of the most recent cycle.
    int     got_rx, got_tx, got_phase;
    longint rx_q[$];
    longint tx_q[$];

    task automatic check_value(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, t);
        end
    endtask

    // One clock cycle: drive, sample, compare against the model, then advance the model.
    task automatic step(input bit r, input bit e, input bit ld, input longint di,
                        input longint df, input bit rs);
        int     exp_rx, exp_tx;
        longint new_d, rx_d;
        @(negedge clk);
        rst           = r;
        bus.en        = e;
        bus.div_load  = ld;
        bus.div_int   = DIV_W'(di);
        bus.div_frac  = FRAC_W'(df);
        bus.rx_resync = rs;
        #1;
        got_rx    = int'(bus.rx_tick);
        got_tx    = int'(bus.tx_tick);
        got_phase = int'(bus.rx_phase);
        exp_rx    = (!r && e && !rs && (x_rx / 16 == t)) ? 1 : 0;
        exp_tx    = (!r && e && (x_tx / 16 == t)) ? 1 : 0;
        if (model_valid) begin
            check_value("rx_tick", longint'(got_rx), longint'(exp_rx));
            check_value("tx_tick", longint'(got_tx), longint'(exp_tx));
            check_value("rx_phase", longint'(got_phase), longint'(phase));
        end
        if (got_rx != 0) rx_q.push_back(t);
        if (got_tx != 0) tx_q.push_back(t);

        new_d = ((di < 2) ? 64'd2 : di) * 16 + df;
        if (r) begin
            shadow_d    = DEF_D;
            x_rx        = 16 * (t + DEF_D / 16);
            x_tx        = 16 * (t + (DEF_D * OS) / 16);
            phase       = 0;
            model_valid = 1'b1;
        end else begin
            if (rs) phase = 0;
            else if (exp_rx != 0) phase = (phase + 1) % OS;
            if (!e) begin
                if (ld) shadow_d = new_d;
                x_rx = 16 * (t + shadow_d / 16);
                x_tx = 16 * (t + (shadow_d * OS) / 16);
            end else begin
                if (rs) begin
                    rx_d = ld ? new_d : shadow_d;
                    x_rx = 16 * (t + rx_d / 16);
                end else if (exp_rx != 0) begin
                    x_rx = x_rx + shadow_d;
                end
                if (exp_tx != 0) x_tx = x_tx + shadow_d * OS;
                if (ld) shadow_d = new_d;
            end
        end
        t++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
    endtask

    // Runs enabled cycles until an rx_tick; n is its 1-based cycle index, -1 on timeout.
    task automatic run_rx(input int max_cycles, output int n);
        n = -1;
        for (int i = 1; i <= max_cycles; i++) begin
            step(1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
            if (got_rx != 0) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        int n;
        int cnt;
        longint iv;

        rst = 1'b1; bus.en = 1'b0; bus.div_load = 1'b0;
        bus.div_int = '0; bus.div_frac = '0; bus.rx_resync = 1'b0;

        // 1. Defaults, en held high.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
        check_value("reset_rx_tick", longint'(got_rx), 0);
        rx_q.delete(); tx_q.delete();
        run_rx(400, n);
        check_value("first_rx_tick_cycle", longint'(n), 195);
        idle(40000 - 195);
        for (int i = 0; i + 1 < rx_q.size(); i++) begin
            iv = rx_q[i+1] - rx_q[i];
            check_value("rx_interval_195_196", (iv == 195 || iv == 196) ? 1 : 0, 1);
        end
        for (int i = 0; i + 16 < rx_q.size(); i += 16)
            check_value("rx_16_tick_span", rx_q[i+16] - rx_q[i], 3125);
        check_value("tx_tick_count_ge12", (tx_q.size() >= 12) ? 1 : 0, 1);
        for (int i = 0; i + 1 < tx_q.size(); i++)
            check_value("tx_interval_default", tx_q[i+1] - tx_q[i], 3125);
        $display("test1 defaults: %0d rx ticks, %0d tx ticks", rx_q.size(), tx_q.size());

        // 2. Load 10 + 8/16 while running.
        rx_q.delete(); tx_q.delete();
        step(1'b0, 1'b1, 1'b1, 10, 8, 1'b0);
        idle(3600);
        n = rx_q.size();
        for (int i = n - 16; i < n - 1; i++) begin
            iv = rx_q[i+1] - rx_q[i];
            check_value("rx_interval_10_11", (iv == 10 || iv == 11) ? 1 : 0, 1);
        end
        check_value("rx_16_tick_span_10p5", rx_q[n-1] - rx_q[n-17], 168);
        n = tx_q.size();
        check_value("tx_tick_count_ge3", (n >= 3) ? 1 : 0, 1);
        check_value("tx_interval_10p5", tx_q[n-1] - tx_q[n-2], 168);
        $display("test2 load 10.5: %0d rx ticks, %0d tx ticks", rx_q.size(), tx_q.size());

        // 3. Load int=0 is clamped to 2.
        rx_q.delete(); tx_q.delete();
        step(1'b0, 1'b1, 1'b1, 0, 0, 1'b0);
        idle(400);
        n = rx_q.size();
        check_value("rx_interval_clamped", rx_q[n-1] - rx_q[n-2], 2);
        n = tx_q.size();
        check_value("tx_interval_clamped", tx_q[n-1] - tx_q[n-2], 32);
        $display("test3 clamp: %0d rx ticks, %0d tx ticks", rx_q.size(), tx_q.size());

        // 4. Resync exactly when rx counter is at zero.
        step(1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
        rx_q.delete(); tx_q.delete();
        cnt = 0;
        while ((x_rx / 16 != t) && cnt < 400) begin
            idle(1);
            cnt++;
        end
        step(1'b0, 1'b1, 1'b0, 0, 0, 1'b1);
        check_value("resync_suppresses_rx_tick", longint'(got_rx), 0);
        run_rx(400, n);
        check_value("rx_tick_after_resync", longint'(n), 195);
        idle(1);
        check_value("rx_phase_after_resync", longint'(got_phase), 1);
        idle(7000);
        check_value("tx_tick_count_resync", (tx_q.size() >= 2) ? 1 : 0, 1);
        for (int i = 0; i + 1 < tx_q.size(); i++)
            check_value("tx_interval_across_resync", tx_q[i+1] - tx_q[i], 3125);
        $display("test4 resync: %0d tx ticks", tx_q.size());

        // 5. en low for 50 cycles mid-period.
        idle(100);
        rx_q.delete(); tx_q.delete();
        for (int i = 0; i < 50; i++) step(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        check_value("ticks_while_disabled", longint'(rx_q.size() + tx_q.size()), 0);
        run_rx(400, n);
        check_value("rx_tick_after_enable", longint'(n), 195);
        $display("test5 enable gap: first rx tick at %0d", n);

        // 6. Reset in the middle of a non-default divisor.
        step(1'b0, 1'b1, 1'b1, 20, 3, 1'b0);
        idle(100);
        step(1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
        check_value("post_rst_rx_tick", longint'(got_rx), 0);
        check_value("post_rst_tx_tick", longint'(got_tx), 0);
        check_value("post_rst_rx_phase", longint'(got_phase), 0);
        run_rx(400, n);
        check_value("rx_tick_after_rst", (n < 0) ? -1 : longint'(n + 1), 195);
        $display("test6 reset: first rx tick at %0d", n + 1);

        // 7. Randomized traffic against the model.
        for (int i = 0; i < 6000; i++) begin
            bit     r, e, ld, rs;
            longint di, df;
            r  = ($urandom_range(0, 1999) == 0);
            e  = ($urandom_range(0, 63) != 0);
            ld = ($urandom_range(0, 199) == 0);
            rs = ($urandom_range(0, 149) == 0);
            di = longint'($urandom_range(0, 24));
            df = longint'($urandom_range(0, 15));
            step(r, e, ld, di, df, rs);
        end
        $display("test7 random: done at cycle %0d", t);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
